// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared state type, default parameters and wrap-safe next-value helper
package count_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  localparam int DEF_W      = 4;
  localparam int DEF_LOCK_N = 2;
  localparam int DEF_ERR_W  = 8;
  localparam int MAX_W      = 32;
  // Result is masked to w bits so up/down wrap stays modulo 2^w for any w <= MAX_W.
  function automatic logic [MAX_W-1:0] next_val(input logic [MAX_W-1:0] v, input logic up, input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (up ? v + MAX_W'(1) : v - MAX_W'(1)) & mask;
  endfunction
endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: observed-counter inputs and monitor status outputs
interface count_monitor_if #(parameter int W = 4, parameter int ERR_W = 8);
  logic             en;
  logic             sel;
  logic [W-1:0]     cnt_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [W-1:0]     exp_out;
  modport master(output en, sel, cnt_in, clr_err, input locked, err_pulse, err_count, exp_out);
  modport slave(input en, sel, cnt_in, clr_err, output locked, err_pulse, err_count, exp_out);
endinterface

// File: rtl/count_monitor.sv
// count_monitor: locks onto an up/down counter and counts step errors once tracking
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERR_W  = DEF_ERR_W
) (
  input logic clk,
  input logic reset,
  count_monitor_if.slave bus
);
  state_t           r_state;
  logic [3:0]       r_match;
  logic [W-1:0]     r_exp;
  logic [ERR_W-1:0] r_err;
  logic             r_pulse;
  logic             r_locked;
  logic [W-1:0]     w_next;
  logic             w_hit;
  logic [3:0]       w_match_inc;
  logic             w_lock;
  logic [ERR_W-1:0] w_err_base;
  logic [ERR_W-1:0] w_err_inc;
  assign w_next      = W'(next_val(MAX_W'(bus.cnt_in), bus.sel, W));
  assign w_hit       = bus.cnt_in == r_exp;
  assign w_match_inc = r_match + 4'd1;
  assign w_lock      = w_match_inc >= 4'(LOCK_N);
  // Clear happens before the increment so clr_err plus an error leaves a count of one.
  assign w_err_base  = bus.clr_err ? '0 : r_err;
  assign w_err_inc   = &w_err_base ? w_err_base : w_err_base + ERR_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_match  <= '0;
      r_exp    <= '0;
      r_err    <= '0;
      r_pulse  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      r_err   <= w_err_base;
      if (!bus.en) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
      end else begin
        r_exp <= w_next;
        case (r_state)
          IDLE: begin
            r_match <= '0;
            r_state <= ACQ;
          end
          ACQ: begin
            r_match <= w_hit ? w_match_inc : 4'd0;
            if (w_hit && w_lock) begin
              r_state  <= TRACK;
              r_locked <= 1'b1;
            end
          end
          TRACK: begin
            if (!w_hit) begin
              r_pulse  <= 1'b1;
              r_err    <= w_err_inc;
              r_match  <= '0;
              r_state  <= ACQ;
              r_locked <= 1'b0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_pulse;
  assign bus.err_count = r_err;
  assign bus.exp_out   = r_exp;
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scoreboard bench with directed scenarios and random stimulus
module tb_count_monitor;
  localparam int W = 4;
  localparam int LOCK_N = 2;
  localparam int ERR_W = 8;
  localparam int MOD = 1 << W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  typedef struct {
    int locked;
    int pulse;
    int err;
    int expv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  exp_t q[$];

  // Reference model: mode 0 = not running, 1 = acquiring, 2 = tracking.
  int m_mode = 0;
  int m_run = 0;
  int m_exp = 0;
  int m_err = 0;
  int m_pulse = 0;

  count_monitor_if #(.W(W), .ERR_W(ERR_W)) bus ();
  count_monitor #(.W(W), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("locked", int'(bus.locked), e.locked);
      chk("err_pulse", int'(bus.err_pulse), e.pulse);
      chk("err_count", int'(bus.err_count), e.err);
      chk("exp_out", int'(bus.exp_out), e.expv);
    end
  end

  task automatic step(input logic e, input logic s, input int c, input logic cl, input logic r);
    int v;
    int nxt;
    exp_t x;
    v = ((c % MOD) + MOD) % MOD;
    @(negedge clk);
    bus.en = e;
    bus.sel = s;
    bus.cnt_in = W'(v);
    bus.clr_err = cl;
    rst = r;
    if (r) begin
      m_mode = 0; m_run = 0; m_exp = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (cl) m_err = 0;
      if (!e) m_mode = 0;
      else begin
        nxt = s ? (v + 1) % MOD : (v + MOD - 1) % MOD;
        if (m_mode == 0) begin
          m_run = 0;
          m_mode = 1;
        end else if (v == m_exp) begin
          if (m_mode == 1) begin
            m_run = m_run + 1;
            if (m_run >= LOCK_N) m_mode = 2;
          end
        end else begin
          m_run = 0;
          if (m_mode == 2) begin
            m_pulse = 1;
            m_err = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
            m_mode = 1;
          end
        end
        m_exp = nxt;
      end
    end
    x.locked = (m_mode == 2) ? 1 : 0;
    x.pulse = m_pulse;
    x.err = m_err;
    x.expv = m_exp;
    q.push_back(x);
  endtask

  task automatic go(input logic s, input int c);
    step(1'b1, s, c, 1'b0, 1'b0);
  endtask

  initial begin
    int c;
    logic s;
    bus.en = 1'b0;
    bus.sel = 1'b0;
    bus.cnt_in = '0;
    bus.clr_err = 1'b0;
    repeat (2) step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    // lock-up, then error and relock
    go(1, 3); go(1, 4); go(1, 5); go(1, 6);
    go(1, 7); go(1, 8); go(1, 10); go(1, 11); go(1, 12);
    // direction change while locked
    go(1, 13); go(0, 14); go(0, 13); go(0, 12);
    // disable while locked: error count held
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 9, 1'b0, 1'b0);
    // wrap-around in both directions
    go(1, 14); go(1, 15); go(1, 0); go(1, 1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    go(0, 1); go(0, 0); go(0, 15); go(0, 14);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    // saturation: lock, then repeated mismatch + relock
    c = 5;
    go(1, c - 3); go(1, c - 2); go(1, c - 1);
    for (int i = 0; i < 260; i++) begin
      go(1, c + 7); go(1, c + 8); go(1, c + 9);
      c = c + 10;
    end
    step(1'b1, 1'b1, c + 7, 1'b1, 1'b0);
    go(1, c + 8); go(1, c + 9);
    step(1'b1, 1'b1, c + 10, 1'b1, 1'b0);
    go(1, c + 11);
    // reset while locked, then fresh acquisition
    step(1'b1, 1'b1, c + 12, 1'b0, 1'b1);
    go(1, 3); go(1, 4); go(1, 5); go(1, 6);
    // random phase
    c = 0;
    s = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int v;
      if ($urandom_range(0, 7) == 0) s = ~s;
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MOD - 1)) : c;
      step($urandom_range(0, 19) != 0, s, v, $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
      c = s ? (c + 1) % MOD : (c + MOD - 1) % MOD;
    end
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
